bram_operand_reader: RTL and testbench

//  Read side of the operand BRAMs: drives BRAM port B (enb/addrb, 1-cycle read latency) and

---
 rtl/bram_operand_reader_pkg.sv | 27 ++
 rtl/bram_operand_reader_if.sv | 12 +
 rtl/bram_operand_reader_skid_fifo.sv | 56 +++++
 rtl/bram_operand_reader.sv | 172 +++++++++++++++++
 tb/tb_bram_operand_reader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bram_operand_reader_pkg.sv
// Shared derived constants and state type for the operand BRAM reader and its peers.
package bram_operand_reader_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} rd_state_e;

  // Words per matrix row.
  function automatic int unsigned calc_row_words(int unsigned inner, int unsigned chunk);
    return inner / chunk;
  endfunction

  // Number of row-blocks in the matrix.
  function automatic int unsigned calc_num_rb(int unsigned outer, int unsigned block);
    return outer / block;
  endfunction

  // Beats streamed by one full traversal.
  function automatic int unsigned calc_total_beats(int unsigned outer, int unsigned inner,
                                                   int unsigned chunk, int unsigned rep);
    return outer * (inner / chunk) * rep;
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_operand_reader_if.sv
// Valid/ready word stream carrying a last-beat marker.
interface bram_operand_reader_if #(
  parameter int unsigned DataW = 64
) ();
  logic             valid;
  logic             ready;
  logic             last;
  logic [DataW-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/bram_operand_reader_skid_fifo.sv
// Two-entry FIFO absorbing read data already in flight when the consumer stalls.
module bram_operand_reader_skid_fifo #(
  parameter int unsigned DataW = 65
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             pop_i,
  output logic [DataW-1:0] rdata_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [DataW-1:0] mem_q [2];
  logic [DataW-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  // Next-state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push_i) - 2'(pop_i);
  end

  // Storage and pointers; reset also zeroes the payload so the output reads 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/bram_operand_reader.sv
// Walks an operand BRAM in row-block tile order, replaying each row-block REPEAT times,
// and streams the words out through a two-entry skid FIFO.
module bram_operand_reader
  import bram_operand_reader_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned CHUNK_SIZE      = 4,
  parameter int unsigned BLOCK_SIZE      = 2,
  parameter int unsigned INNER_DIMENSION = 256,
  parameter int unsigned OUTER_DIMENSION = 2754,
  parameter int unsigned REPEAT          = 32,
  parameter int unsigned ADDR_W          = 18,
  localparam int unsigned DATA_W         = WIDTH * CHUNK_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb,
  bram_operand_reader_if.master m_if
);

  localparam int unsigned ROW_WORDS = calc_row_words(INNER_DIMENSION, CHUNK_SIZE);
  localparam int unsigned NUM_RB    = calc_num_rb(OUTER_DIMENSION, BLOCK_SIZE);
  localparam int unsigned KW        = cnt_w(ROW_WORDS);
  localparam int unsigned RW        = cnt_w(BLOCK_SIZE);
  localparam int unsigned PW        = cnt_w(REPEAT);
  localparam int unsigned BW        = cnt_w(NUM_RB);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] BlkStep = ADDR_W'(BLOCK_SIZE * ROW_WORDS);

  if ((OUTER_DIMENSION % BLOCK_SIZE) != 0) begin : g_bad_outer
    $error("OUTER_DIMENSION must be a multiple of BLOCK_SIZE");
  end

  rd_state_e         st_q, st_d;
  logic [KW-1:0]     k_q, k_d;
  logic [RW-1:0]     r_q, r_d;
  logic [PW-1:0]     p_q, p_d;
  logic [BW-1:0]     rb_q, rb_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;  // (rb*BLOCK_SIZE + r) * ROW_WORDS
  logic [ADDR_W-1:0] blk_base_q, blk_base_d;  // rb * BLOCK_SIZE * ROW_WORDS
  logic              in_flight_q, in_flight_d;
  logic              in_last_q, in_last_d;
  logic              done_q, done_d;

  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic              k_last, r_last, p_last, rb_last;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [DATA_W:0]   fifo_rdata;

  assign k_last  = (k_q == KW'(ROW_WORDS - 1));
  assign r_last  = (r_q == RW'(BLOCK_SIZE - 1));
  assign p_last  = (p_q == PW'(REPEAT - 1));
  assign rb_last = (rb_q == BW'(NUM_RB - 1));

  // Pop frees a slot this same edge, which keeps one beat per clock sustainable.
  assign pop   = fifo_valid & m_if.ready;
  assign occ   = 3'(fifo_count) + 3'(in_flight_q) - 3'(pop);
  assign issue = (st_q == StRun) && (occ < 3'd2);

  // FSM and traversal counters.
  always_comb begin
    st_d        = st_q;
    k_d         = k_q;
    r_d         = r_q;
    p_d         = p_q;
    rb_d        = rb_q;
    row_addr_d  = row_addr_q;
    blk_base_d  = blk_base_q;
    in_flight_d = issue;
    in_last_d   = k_last & r_last;
    done_d      = 1'b0;

    if (issue) begin
      if (!r_last) begin
        r_d        = r_q + RW'(1);
        row_addr_d = row_addr_q + RowStep;
      end else begin
        r_d        = '0;
        row_addr_d = blk_base_q;
        if (!k_last) begin
          k_d = k_q + KW'(1);
        end else begin
          k_d = '0;
          if (!p_last) begin
            p_d = p_q + PW'(1);
          end else begin
            p_d = '0;
            if (!rb_last) begin
              rb_d       = rb_q + BW'(1);
              blk_base_d = blk_base_q + BlkStep;
              row_addr_d = blk_base_q + BlkStep;
            end else begin
              // Final read: everything returns to zero for the next traversal.
              rb_d       = '0;
              blk_base_d = '0;
              row_addr_d = '0;
            end
          end
        end
      end
    end

    unique case (st_q)
      StIdle:  if (start) st_d = StRun;
      StRun:   if (issue && k_last && r_last && p_last && rb_last) st_d = StDrain;
      StDrain: begin
        if (!in_flight_q && (fifo_count == 2'd1) && pop) begin
          st_d   = StIdle;
          done_d = 1'b1;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      k_q         <= '0;
      r_q         <= '0;
      p_q         <= '0;
      rb_q        <= '0;
      row_addr_q  <= '0;
      blk_base_q  <= '0;
      in_flight_q <= 1'b0;
      in_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      k_q         <= k_d;
      r_q         <= r_d;
      p_q         <= p_d;
      rb_q        <= rb_d;
      row_addr_q  <= row_addr_d;
      blk_base_q  <= blk_base_d;
      in_flight_q <= in_flight_d;
      in_last_q   <= in_last_d;
      done_q      <= done_d;
    end
  end

  bram_operand_reader_skid_fifo #(
    .DataW (DATA_W + 1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (in_flight_q),
    .wdata_i ({in_last_q, bram_doutb}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign ready      = (st_q == StIdle);
  assign done       = done_q;
  assign bram_enb   = issue;
  assign bram_addrb = row_addr_q + ADDR_W'(k_q);
  assign m_if.valid = fifo_valid;
  assign m_if.data  = fifo_rdata[DATA_W-1:0];
  assign m_if.last  = fifo_rdata[DATA_W];

endmodule

// File: tb/tb_bram_operand_reader.sv
// Directed bench for bram_operand_reader in a small configuration with a beat scoreboard.
module tb_bram_operand_reader;

  localparam int Blk   = 2;
  localparam int RowW  = 2;
  localparam int Outer = 4;
  localparam int Rep   = 2;
  localparam int Beats = Outer * RowW * Rep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready, done, bram_enb;
  logic [7:0]  bram_addrb;
  logic [63:0] bram_doutb = '0;

  bram_operand_reader_if #(.DataW(64)) s_if ();

  bram_operand_reader #(
    .WIDTH           (16),
    .CHUNK_SIZE      (4),
    .BLOCK_SIZE      (Blk),
    .INNER_DIMENSION (8),
    .OUTER_DIMENSION (Outer),
    .REPEAT          (Rep),
    .ADDR_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready      (ready),
    .done       (done),
    .bram_enb   (bram_enb),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb),
    .m_if       (s_if)
  );

  always #5 clk = ~clk;

  // BRAM model: word[a] = a, one-cycle read latency.
  always @(posedge clk) if (bram_enb) bram_doutb <= 64'(bram_addrb);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued, beats, dones, enb_cnt;
  int start_cyc, first_valid_cyc, last_beat_cyc;
  bit busy, pend, prev_stall, prev_last;
  logic [63:0] prev_data;
  logic [63:0] sb_data[$];
  logic        sb_last[$];
  int          exp_addr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_enb", bram_enb, 0);
    chk("rst_addrb", bram_addrb, 0);
    chk("rst_valid", s_if.valid, 0);
    chk("rst_data", s_if.data, 0);
    chk("rst_last", s_if.last, 0);
  endtask

  // Per-cycle monitor, sampled mid-cycle after inputs have settled.
  task automatic observe();
    logic pop;
    logic [63:0] ed;
    logic el;
    if (rst) begin
      busy = 0; pend = 0; prev_stall = 0;
      return;
    end
    pop = s_if.valid & s_if.ready;
    if (pend) begin busy = 1; pend = 0; end
    if (done) begin
      dones++;
      chk("done_latency", cyc, last_beat_cyc + 1);
      chk("ready_at_done", ready, 1);
      busy = 0;
    end
    if (busy) chk("ready_low_busy", ready, 0);
    if (start && ready) begin pend = 1; start_cyc = cyc; end
    if (prev_stall) begin
      chk("stall_valid", s_if.valid, 1);
      chk("stall_data", s_if.data, prev_data);
      chk("stall_last", s_if.last, prev_last);
    end
    prev_stall = s_if.valid && !s_if.ready;
    prev_data  = s_if.data;
    prev_last  = s_if.last;
    if (s_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop) begin
      if (sb_data.size() == 0) begin
        chk("beat_beyond_expected", sb_data.size(), 1);
      end else begin
        ed = sb_data.pop_front();
        el = sb_last.pop_front();
        chk("m_data", s_if.data, ed);
        chk("m_last", s_if.last, el);
      end
      beats++;
      last_beat_cyc = cyc;
    end
    if (bram_enb) begin
      chk("enb_fifo_space", (issued - beats) < 2, 1);
      if (issued < exp_addr.size()) chk("addrb", bram_addrb, 64'(exp_addr[issued]));
      else chk("issue_beyond_expected", issued, exp_addr.size() - 1);
      issued++;
      enb_cnt++;
    end
  endtask

  task automatic cycle(input logic rdy, input logic st, input logic rs);
    @(posedge clk);
    #1;
    s_if.ready = rdy;
    start = st;
    rst = rs;
    #1;
    cyc++;
    observe();
  endtask

  // mode 0: ready high; 2: ready 1,0,0,1; 3: ready low 10 clk; 4: extra starts; 5: mid reset
  task automatic run_traversal(input int mode);
    int rst_phase = 0;
    int post = 0;
    sb_data.delete(); sb_last.delete(); exp_addr.delete();
    for (int rb = 0; rb < Outer / Blk; rb++)
      for (int p = 0; p < Rep; p++)
        for (int k = 0; k < RowW; k++)
          for (int r = 0; r < Blk; r++) begin
            exp_addr.push_back((rb * Blk + r) * RowW + k);
            sb_data.push_back(64'((rb * Blk + r) * RowW + k));
            sb_last.push_back((k == RowW - 1) && (r == Blk - 1));
          end
    issued = 0; beats = 0; dones = 0; enb_cnt = 0;
    first_valid_cyc = -1; last_beat_cyc = -10; start_cyc = -1;
    prev_stall = 0;
    for (int n = 0; n < 300; n++) begin
      logic rdy, st, rs;
      st = (n == 0) || (mode == 4 && (n == 6 || n == 14));
      rs = 1'b0;
      case (mode)
        2:       rdy = (n % 4 == 0) || (n % 4 == 3);
        3:       rdy = (n > 10);
        default: rdy = 1'b1;
      endcase
      if (mode == 5 && rst_phase == 1) begin
        rs = 1'b1; rdy = 1'b0; rst_phase = 2;
        cycle(rdy, st, rs);
        continue;
      end
      cycle(rdy, st, rs);
      if (mode == 5 && rst_phase == 2) begin
        chk_reset_outputs();
        chk("no_done_after_abort", dones, 0);
        return;
      end
      if (mode == 5 && rst_phase == 0 && beats >= 5) rst_phase = 1;
      if (mode == 3 && n == 10) chk("reads_while_stalled", enb_cnt, 2);
      if (dones > 0) post++;
      if (post >= 6) break;
    end
    chk("beat_count", beats, Beats);
    chk("done_count", dones, 1);
    chk("issue_count", issued, Beats);
    chk("sb_drained", sb_data.size(), 0);
    if (mode == 0) begin
      chk("first_valid_latency", first_valid_cyc - start_cyc, 3);
      chk("no_bubbles", last_beat_cyc - first_valid_cyc, Beats - 1);
    end
  endtask

  initial begin
    s_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk_reset_outputs();

    run_traversal(0);
    run_traversal(2);
    run_traversal(3);
    run_traversal(4);
    run_traversal(5);
    run_traversal(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
